rob_alloc_ctrl: RTL

Allocation and occupancy controller for the 16-entry reorder buffer. It sits between the dual-issue dispatch stage and the ROB.
- Hands out ROB numbers, up to 2 per cycle, in program order from a circular tail pointer.
- Tracks the head pointer as the ROB retires entries, up to 2 per cycle.
- Publishes full/empty/stall status so dispatch can hold instructions when the ROB lacks space.

---
 rtl/rob_alloc_ctrl_pkg.sv | 21 ++
 rtl/rob_alloc_ctrl_if.sv | 45 ++++
 rtl/rob_alloc_ctrl_grant.sv | 31 +++
 rtl/rob_alloc_ctrl.sv | 113 +++++++++++
 4 files changed

// File: rtl/rob_alloc_ctrl_pkg.sv
// Shared types and constants for the ROB allocation controller.
// Optional flush support is enabled by defining ROB_FLUSH_EN.
package rob_alloc_ctrl_pkg;

    localparam int ROB_DEPTH = 16;
    localparam int ROB_PTR_W = 4;
    localparam int ISSUE_W   = 2;

    typedef logic [ROB_PTR_W-1:0] rob_ptr_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } alloc_ctrl_state_t;

    // Number of set bits in a two-slot vector.
    function automatic logic [1:0] popcount2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/rob_alloc_ctrl_if.sv
// Dispatch/retire-side bundle for the ROB allocation controller.
// i_flush exists only when ROB_FLUSH_EN is defined.
interface rob_alloc_ctrl_if
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int PTR_W = ROB_PTR_W
);
    logic [ISSUE_W-1:0] i_alloc_req;
    logic [ISSUE_W-1:0] o_alloc_grant;
    logic [PTR_W-1:0]   o_alloc_rob_num0;
    logic [PTR_W-1:0]   o_alloc_rob_num1;
    logic [1:0]         i_retire_cnt;
    logic [PTR_W-1:0]   o_head;
    logic [PTR_W-1:0]   o_tail;
    logic [PTR_W:0]     o_count;
    logic               o_full;
    logic               o_empty;
    logic               o_stall;
    logic               o_err;
`ifdef ROB_FLUSH_EN
    logic               i_flush;

    modport master (
        output i_alloc_req, i_retire_cnt, i_flush,
        input  o_alloc_grant, o_alloc_rob_num0, o_alloc_rob_num1,
               o_head, o_tail, o_count, o_full, o_empty, o_stall, o_err
    );
    modport slave (
        input  i_alloc_req, i_retire_cnt, i_flush,
        output o_alloc_grant, o_alloc_rob_num0, o_alloc_rob_num1,
               o_head, o_tail, o_count, o_full, o_empty, o_stall, o_err
    );
`else
    modport master (
        output i_alloc_req, i_retire_cnt,
        input  o_alloc_grant, o_alloc_rob_num0, o_alloc_rob_num1,
               o_head, o_tail, o_count, o_full, o_empty, o_stall, o_err
    );
    modport slave (
        input  i_alloc_req, i_retire_cnt,
        output o_alloc_grant, o_alloc_rob_num0, o_alloc_rob_num1,
               o_head, o_tail, o_count, o_full, o_empty, o_stall, o_err
    );
`endif
endinterface

// File: rtl/rob_alloc_ctrl_grant.sv
// Combinational in-order grant and ROB numbering for two dispatch slots.
// Slot 1 never gets a row ahead of a requesting-but-denied slot 0.
module rob_grant_logic
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int PTR_W = ROB_PTR_W
) (
    input  logic [1:0]       req,
    input  logic [PTR_W:0]   free,
    input  logic [PTR_W-1:0] tail,
    output logic [1:0]       grant,
    output logic [PTR_W-1:0] num0,
    output logic [PTR_W-1:0] num1,
    output logic [1:0]       alloc_n
);
    logic has1;
    logic has2;

    // Grant the oldest requesting slots first; the second granted slot takes tail+1.
    always_comb begin
        has1     = (free >= (PTR_W+1)'(1));
        has2     = (free >= (PTR_W+1)'(2));
        grant    = 2'b00;
        grant[0] = req[0] && has1;
        grant[1] = req[1] && (req[0] ? (has1 && has2) : has1);
        num0     = tail;
        num1     = req[0] ? tail + PTR_W'(1) : tail;
        alloc_n  = popcount2(grant);
    end

endmodule

// File: rtl/rob_alloc_ctrl.sv
// ROB allocation/occupancy controller: hands out up to two ROB numbers per
// cycle from a circular tail, tracks the head as rows retire, and reports
// full/empty/stall. Defining ROB_FLUSH_EN adds i_flush and a one-cycle
// FLUSH bubble that clears all pointers.
module rob_alloc_ctrl
    import rob_alloc_ctrl_pkg::*;
#(
    parameter int DEPTH = ROB_DEPTH,
    parameter int PTR_W = ROB_PTR_W
) (
    input  logic             i_clk,
    input  logic             i_rst,
    rob_alloc_ctrl_if.slave  bus
);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);

    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [PTR_W:0]   count_q;
    logic             err_q;

    logic             run;
    logic             flush_now;
    logic [1:0]       req_eff;
    logic [PTR_W:0]   free;
    logic [1:0]       grant;
    logic [1:0]       alloc_n;
    logic [PTR_W-1:0] num0;
    logic [PTR_W-1:0] num1;
    logic [PTR_W:0]   retire_ext;
    logic [PTR_W:0]   r;
    logic             err_set;

`ifdef ROB_FLUSH_EN
    alloc_ctrl_state_t state_q;
    alloc_ctrl_state_t state_d;

    // Flush state register; reset wins over a pending flush.
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= RUN;
        else       state_q <= state_d;
    end

    // FLUSH is a single bubble cycle entered from RUN on i_flush.
    always_comb begin
        state_d = state_q;
        case (state_q)
            RUN:     if (bus.i_flush) state_d = FLUSH;
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    assign run       = (state_q == RUN);
    assign flush_now = run && bus.i_flush;
`else
    assign run       = 1'b1;
    assign flush_now = 1'b0;
`endif

    // Space comes only from the registered count; same-cycle retires do not free rows.
    assign free    = DEPTH_C - count_q;
    assign req_eff = run ? bus.i_alloc_req : 2'b00;

    rob_grant_logic #(.PTR_W(PTR_W)) u_grant (
        .req     (req_eff),
        .free    (free),
        .tail    (tail_q),
        .grant   (grant),
        .num0    (num0),
        .num1    (num1),
        .alloc_n (alloc_n)
    );

    // Retire amount clamped to occupancy; overdraw or the illegal code 3 flags an error.
    always_comb begin
        retire_ext = {{(PTR_W-1){1'b0}}, bus.i_retire_cnt};
        r          = (retire_ext > count_q) ? count_q : retire_ext;
        err_set    = run && ((retire_ext > count_q) || (bus.i_retire_cnt == 2'b11));
        if (!run) r = '0;
    end

    // Pointer/occupancy update; allocation and retirement apply together.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else if (flush_now) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            tail_q  <= tail_q + PTR_W'(alloc_n);
            head_q  <= head_q + PTR_W'(r);
            count_q <= count_q + (PTR_W+1)'(alloc_n) - r;
            err_q   <= err_q | err_set;
        end
    end

    assign bus.o_alloc_grant    = grant;
    assign bus.o_alloc_rob_num0 = num0;
    assign bus.o_alloc_rob_num1 = num1;
    assign bus.o_head           = head_q;
    assign bus.o_tail           = tail_q;
    assign bus.o_count          = count_q;
    assign bus.o_full           = (count_q == DEPTH_C);
    assign bus.o_empty          = (count_q == '0);
    assign bus.o_stall          = |(bus.i_alloc_req & ~grant);
    assign bus.o_err            = err_q;

endmodule
